// File: rtl/divider_recon_pkg.sv
// Shared definitions for the q*d+r dividend reconstruction engine.
//   WIDTH_DEF : default operand width (q, d, r); result width is 2*WIDTH
//   SSE_W     : width of the sum-of-squared-errors accumulator
//   CNT_W     : width of the sample counter
//   state_t   : controller states IDLE / MUL / DONE
package divider_recon_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int SSE_W     = 40;
  localparam int CNT_W     = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/divider_recon_step.sv
// One radix-2 shift-add multiply step, purely combinational.
//   acc        : running sum (2*WIDTH)
//   mcand      : multiplicand aligned to the current quotient bit (2*WIDTH)
//   qbit       : current quotient bit (LSB of the quotient shift register)
//   acc_next   : acc + mcand when qbit is set, otherwise acc
//   mcand_next : mcand shifted left by one, aligned to the next quotient bit
module divider_recon_step #(
  parameter int WIDTH = 8
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [2*WIDTH-1:0] mcand,
  input  logic               qbit,
  output logic [2*WIDTH-1:0] acc_next,
  output logic [2*WIDTH-1:0] mcand_next
);

  // No carry-out needed: q*d + r never exceeds 2^(2W) - 2^W.
  assign acc_next   = qbit ? (acc + mcand) : acc;
  assign mcand_next = {mcand[2*WIDTH-2:0], 1'b0};

endmodule

// File: rtl/divider_reconstruct_seq.sv
// Sequential dividend reconstruction: n_rec = q*d + r, one quotient bit per
// cycle. The accumulator is seeded with r, so the remainder costs no extra
// cycle.
//
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   in_valid/in_ready, q, d, r : operand triple input handshake
//   out_valid/out_ready, n_rec : result output handshake
//   busy          : high while the shift-add loop is running (MUL state)
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. in_ready is high only in IDLE. Once out_valid rises, n_rec
// and out_valid hold until the edge where out_ready is also high.
//
// Optional feature, macro DIVIDER_RECON_ERROR_METRIC_EN, adds:
//   n_ref       : original dividend, captured together with the operands
//   clear_stats : clears sse and sample_cnt (takes priority over accumulate)
//   err_abs     : |n_ref - n_rec|, valid while out_valid is high
//   sse         : saturating sum of err_abs^2 over output handshakes
//   sample_cnt  : saturating count of output handshakes
module divider_reconstruct_seq
  import divider_recon_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   q,
  input  logic [WIDTH-1:0]   d,
  input  logic [WIDTH-1:0]   r,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] n_rec,
  output logic               busy
`ifdef DIVIDER_RECON_ERROR_METRIC_EN
  ,
  input  logic [2*WIDTH-1:0] n_ref,
  input  logic               clear_stats,
  output logic [2*WIDTH-1:0] err_abs,
  output logic [SSE_W-1:0]   sse,
  output logic [CNT_W-1:0]   sample_cnt
`endif
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t             state;
  state_t             state_next;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   qreg;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc_step;
  logic [2*WIDTH-1:0] mcand_step;
  logic               accept;
  logic               last_step;

  divider_recon_step #(.WIDTH(WIDTH)) u_step (
    .acc        (acc),
    .mcand      (mcand),
    .qbit       (qreg[0]),
    .acc_next   (acc_step),
    .mcand_next (mcand_step)
  );

  assign accept    = in_valid && in_ready;
  assign last_step = (cnt == CW'(WIDTH - 1));

  // Next state and handshake outputs.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    busy       = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = MUL;
      end
      MUL: begin
        busy = 1'b1;
        if (last_step) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Datapath. The loop always runs WIDTH steps, even for q=0 or d=0, so the
  // latency stays fixed.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc   <= '0;
      mcand <= '0;
      qreg  <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            acc   <= {{WIDTH{1'b0}}, r};
            mcand <= {{WIDTH{1'b0}}, d};
            qreg  <= q;
            cnt   <= '0;
          end
        end
        MUL: begin
          acc   <= acc_step;
          mcand <= mcand_step;
          qreg  <= qreg >> 1;
          cnt   <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign n_rec = (state == DONE) ? acc : '0;

`ifdef DIVIDER_RECON_ERROR_METRIC_EN
  logic [2*WIDTH-1:0] nref_reg;
  logic [2*WIDTH-1:0] diff;
  logic [4*WIDTH-1:0] err_sq;
  logic [SSE_W:0]     sse_sum;
  logic               out_fire;

  assign diff     = (acc >= nref_reg) ? (acc - nref_reg) : (nref_reg - acc);
  assign err_abs  = (state == DONE) ? diff : '0;
  assign err_sq   = (4*WIDTH)'(err_abs) * (4*WIDTH)'(err_abs);
  assign sse_sum  = {1'b0, sse} + (SSE_W + 1)'(err_sq);
  assign out_fire = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      nref_reg   <= '0;
      sse        <= '0;
      sample_cnt <= '0;
    end else begin
      if (accept) nref_reg <= n_ref;
      if (clear_stats) begin
        sse        <= '0;
        sample_cnt <= '0;
      end else if (out_fire) begin
        // Carry out of the accumulator means saturation.
        sse <= sse_sum[SSE_W] ? {SSE_W{1'b1}} : sse_sum[SSE_W-1:0];
        if (sample_cnt != {CNT_W{1'b1}}) sample_cnt <= sample_cnt + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_divider_reconstruct_seq.sv
// Bench for divider_reconstruct_seq (WIDTH=8): directed cases plus random
// operands with random output back-pressure. Expected dividends come from
// q*d+r in plain integer arithmetic and are queued at issue; a negedge
// monitor pops and compares whenever out_valid is high.
module tb_divider_reconstruct_seq;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [W-1:0]   q = '0;
  logic [W-1:0]   d = '0;
  logic [W-1:0]   r = '0;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [2*W-1:0] n_rec;
  logic           busy;

`ifdef DIVIDER_RECON_ERROR_METRIC_EN
  logic [2*W-1:0] n_ref = '0;
  logic           clear_stats = 1'b0;
  logic [2*W-1:0] err_abs;
  logic [39:0]    sse;
  logic [31:0]    sample_cnt;
  logic [2*W-1:0] err_q[$];
  int             force_nref = -1;
  logic [39:0]    m_sse = '0;
  logic [31:0]    m_cnt = '0;
`endif

  divider_reconstruct_seq #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .q           (q),
    .d           (d),
    .r           (r),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .n_rec       (n_rec),
    .busy        (busy)
`ifdef DIVIDER_RECON_ERROR_METRIC_EN
    ,
    .n_ref       (n_ref),
    .clear_stats (clear_stats),
    .err_abs     (err_abs),
    .sse         (sse),
    .sample_cnt  (sample_cnt)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [2*W-1:0] exp_q[$];
  int             lat_q[$];
  int             checks = 0;
  int             failures = 0;

  function automatic void chk(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // ---------------- output back-pressure ----------------
  // 0: always ready, 1: never ready, 2: random
  int bp_mode = 0;
  always @(posedge clk) begin
    #2;
    case (bp_mode)
      0: out_ready = 1'b1;
      1: out_ready = 1'b0;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // ---------------- driver ----------------
  // Called just after a rising edge; returns just after the accept edge.
  task automatic send(input logic [W-1:0] qv, input logic [W-1:0] dv,
                      input logic [W-1:0] rv, input bit keep);
    int tmo;
    int expv;
    expv = int'(qv) * int'(dv) + int'(rv);
    q = qv; d = dv; r = rv;
    in_valid = 1'b1;
`ifdef DIVIDER_RECON_ERROR_METRIC_EN
    begin
      int nr;
      if (force_nref >= 0) nr = force_nref;
      else nr = expv + int'($urandom_range(0, 6)) - 3;
      if (nr < 0) nr = 0;
      if (nr > 65535) nr = 65535;
      n_ref = 16'(nr);
      if (keep) err_q.push_back(16'((nr > expv) ? (nr - expv) : (expv - nr)));
    end
`endif
    tmo = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      tmo++;
      if (tmo > 200) begin
        $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, required 1", tmo);
        $fatal(1);
      end
    end
    if (keep) begin
      exp_q.push_back(16'(expv));
      lat_q.push_back(cyc);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int tmo;
    tmo = 0;
    while (exp_q.size() != 0) begin
      @(posedge clk); #1;
      tmo++;
      if (tmo > 2000) begin
        $display("FAIL drain_timeout: %0d results outstanding, required 0", exp_q.size());
        $fatal(1);
      end
    end
  endtask

  // ---------------- monitor ----------------
  bit             rst_seen = 1'b0;
  bit             acc_pending = 1'b0;
  bit             prev_valid = 1'b0;
  bit             prev_ready = 1'b0;
  logic [2*W-1:0] prev_nrec = '0;

  always @(negedge clk) begin
    if (rst_seen) begin
      chk("reset_in_ready", in_ready, 1);
      chk("reset_out_valid", out_valid, 0);
      chk("reset_busy", busy, 0);
      chk("reset_n_rec", n_rec, 0);
`ifdef DIVIDER_RECON_ERROR_METRIC_EN
      chk("reset_sse", sse, 0);
      chk("reset_sample_cnt", sample_cnt, 0);
      chk("reset_err_abs", err_abs, 0);
`endif
    end else begin
      if (acc_pending) begin
        chk("accept_busy", busy, 1);
        chk("accept_in_ready", in_ready, 0);
      end
      if (busy || out_valid) chk("in_ready_low_when_occupied", in_ready, 0);
      if (prev_valid && !prev_ready) begin
        chk("hold_out_valid", out_valid, 1);
        chk("hold_n_rec", n_rec, prev_nrec);
      end
`ifdef DIVIDER_RECON_ERROR_METRIC_EN
      chk("sse", sse, m_sse);
      chk("sample_cnt", sample_cnt, m_cnt);
`endif
      if (out_valid) begin
        if (!prev_valid) begin
          if (lat_q.size() == 0) chk("unexpected_latency_slot", 1, 0);
          else chk("latency", cyc - lat_q.pop_front(), W + 1);
        end
        if (exp_q.size() == 0) begin
          chk("unexpected_out_valid", 1, 0);
        end else begin
          chk("n_rec", n_rec, exp_q[0]);
`ifdef DIVIDER_RECON_ERROR_METRIC_EN
          if (err_q.size() != 0) chk("err_abs", err_abs, err_q[0]);
`endif
          if (out_ready) begin
            void'(exp_q.pop_front());
`ifdef DIVIDER_RECON_ERROR_METRIC_EN
            if (err_q.size() != 0) begin
              longint e;
              longint s;
              e = longint'(err_q.pop_front());
              s = longint'(m_sse) + e * e;
              m_sse = (s > 64'hFF_FFFF_FFFF) ? 40'hFF_FFFF_FFFF : 40'(s);
              if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
            end
`endif
          end
        end
      end
`ifdef DIVIDER_RECON_ERROR_METRIC_EN
      if (clear_stats) begin
        m_sse = '0;
        m_cnt = '0;
      end
`endif
    end
    acc_pending = in_valid && in_ready && !rst;
    prev_valid  = out_valid && !rst;
    prev_ready  = out_ready;
    prev_nrec   = n_rec;
`ifdef DIVIDER_RECON_ERROR_METRIC_EN
    if (rst) begin
      m_sse = '0;
      m_cnt = '0;
    end
`endif
    rst_seen = rst;
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(2);

`ifdef DIVIDER_RECON_ERROR_METRIC_EN
    force_nref = 40;
    send(8'd5, 8'd7, 8'd3, 1'b1);
    force_nref = 35;
    send(8'd5, 8'd7, 8'd3, 1'b1);
    drain();
    idle(2);
    clear_stats = 1'b1;
    idle(1);
    clear_stats = 1'b0;
    force_nref = -1;
    idle(2);
`endif

    // directed cases with out_ready tied high
    bp_mode = 0;
    send(8'd5, 8'd7, 8'd3, 1'b1);
    send(8'd255, 8'd255, 8'd255, 1'b1);
    send(8'd0, 8'd200, 8'd17, 1'b1);
    send(8'd9, 8'd0, 8'd4, 1'b1);
    send(8'd3, 8'd5, 8'd250, 1'b1);   // r >= d, summed exactly
    drain();
    idle(2);

    // result held under back-pressure for 5 cycles
    bp_mode = 1;
    send(8'd12, 8'd10, 8'd1, 1'b1);
    begin
      int tmo;
      tmo = 0;
      while (!out_valid) begin
        @(posedge clk); #1;
        tmo++;
        if (tmo > 50) begin
          $display("FAIL hold_wait: out_valid stayed 0 for %0d cycles, required 1", tmo);
          $fatal(1);
        end
      end
    end
    idle(5);
    bp_mode = 0;
    drain();
    idle(2);

    // reset in the middle of the loop discards the operation
    send(8'd3, 8'd3, 8'd0, 1'b0);
    idle(3);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    idle(12);
    send(8'd2, 8'd3, 8'd1, 1'b1);
    drain();

    // random operands, random back-pressure, random issue gaps
    bp_mode = 2;
    for (int i = 0; i < 40; i++) begin
      send(W'($urandom), W'($urandom), W'($urandom), 1'b1);
      idle($urandom_range(0, 3));
    end
    bp_mode = 0;
    drain();
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
